key_schedule_iter: RTL and testbench

//  Iterative, multi-length AES key schedule. Supports AES-128, AES-192 and AES-256.

---
 rtl/key_schedule_iter.sv | 246 ++++++++++++++++++++++++
 tb/tb_key_schedule_iter.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/key_schedule_iter.sv
// key_schedule_iter
// Iterative AES key expander for AES-128/192/256. It produces one 32-bit
// schedule word per clock through a single shared SubWord (4 S-boxes) and
// keeps every round key in an internal word store. The cipher core reads the
// store through a read port that is either registered or combinational.
//
// Ports
//   clk, rst      : single rising-edge clock; synchronous active-high reset
//   start         : expansion request, sampled only while idle
//   key_len       : 0=AES-128, 1=AES-192, 2=AES-256, 3=illegal
//   key           : cipher key, left-aligned (w[0] = key[255:224])
//   busy          : high while schedule words are being generated
//   done          : one-cycle pulse when the schedule is complete
//   key_ready     : store holds a complete schedule
//   err           : one-cycle pulse for a start with an unsupported key_len
//   rk_rd_en      : round-key read strobe
//   rk_rd_idx     : round index 0..Nr
//   rk_rd_data    : {w[4r], w[4r+1], w[4r+2], w[4r+3]}, zero when not ready
//                   or when the index is beyond Nr
//   rk_rd_valid   : read response qualifier, RD_REG cycles after rk_rd_en
//   dbg_state     : current FSM state (IDLE=0, EXPAND=1, DONE=2)
//
// Handshake: a read is a single-cycle strobe with no back-pressure; every
// strobe produces exactly one rk_rd_valid cycle carrying its data.
module key_schedule_iter #(
    parameter int MAX_NK = 8,
    parameter bit RD_REG = 1'b1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic [1:0]   key_len,
    input  logic [255:0] key,
    output logic         busy,
    output logic         done,
    output logic         key_ready,
    output logic         err,
    input  logic         rk_rd_en,
    input  logic [3:0]   rk_rd_idx,
    output logic [127:0] rk_rd_data,
    output logic         rk_rd_valid,
    output logic [1:0]   dbg_state
);

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_EXPAND = 2'd1;
    localparam logic [1:0] S_DONE   = 2'd2;

    // AES S-box, entry 0 in the most significant byte.
    localparam logic [2047:0] SBOX = {
        128'h637c777bf26b6fc53001672bfed7ab76,
        128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115,
        128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84,
        128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8,
        128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973,
        128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479,
        128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
        128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df,
        128'h8ca1890dbfe6426841992d0fb054bb16
    };

    function automatic logic [7:0] sbox(input logic [7:0] b);
        logic [10:0] msb;
        msb = 11'd2047 - {b, 3'b000};
        return SBOX[msb -: 8];
    endfunction

    function automatic logic [31:0] sub_word(input logic [31:0] x);
        return {sbox(x[31:24]), sbox(x[23:16]), sbox(x[15:8]), sbox(x[7:0])};
    endfunction

    // Word store is sized for the full 6-bit address so any read index maps
    // to a real entry; it is deliberately not reset.
    logic [31:0] r_w [0:63];

    logic [1:0] r_state;
    logic [3:0] r_nk;
    logic [3:0] r_nr;
    logic [5:0] r_nw;
    logic [5:0] r_i;
    logic [2:0] r_mod;      // i mod Nk, wraps at Nk
    logic [7:0] r_rcon;
    logic       r_done;
    logic       r_key_ready;
    logic       r_err;

    logic [3:0]  w_nk;
    logic        w_len_ok;
    logic        w_accept;
    logic [31:0] w_prev;
    logic [31:0] w_back;
    logic [31:0] w_sub_in;
    logic [31:0] w_sub;
    logic [31:0] w_t;
    logic [31:0] w_new;
    logic        w_mod0;
    logic        w_mod4_256;
    logic [7:0]  w_rcon_next;

    always_comb begin
        w_nk = 4'd0;
        case (key_len)
            2'd0:    w_nk = 4'd4;
            2'd1:    w_nk = 4'd6;
            2'd2:    w_nk = 4'd8;
            default: w_nk = 4'd0;
        endcase
    end

    assign w_len_ok = (key_len != 2'd3) && (int'(w_nk) <= MAX_NK);
    assign w_accept = (r_state == S_IDLE) && start && w_len_ok;

    assign w_prev     = r_w[r_i - 6'd1];
    assign w_back     = r_w[r_i - {2'b00, r_nk}];
    assign w_mod0     = (r_mod == 3'd0);
    assign w_mod4_256 = (r_nk == 4'd8) && (r_mod == 3'd4);

    // One SubWord serves both the RotWord step and the AES-256 mid-key step.
    assign w_sub_in = w_mod0 ? {w_prev[23:0], w_prev[31:24]} : w_prev;
    assign w_sub    = sub_word(w_sub_in);

    always_comb begin
        w_t = w_prev;
        if (w_mod0) begin
            w_t = w_sub ^ {r_rcon, 24'h000000};
        end else if (w_mod4_256) begin
            w_t = w_sub;
        end
    end

    assign w_new       = w_back ^ w_t;
    assign w_rcon_next = {r_rcon[6:0], 1'b0} ^ (r_rcon[7] ? 8'h1b : 8'h00);

    always_ff @(posedge clk) begin
        if (w_accept) begin
            for (int k = 0; k < 8; k++) begin
                if (k < int'(w_nk)) begin
                    r_w[6'(k)] <= key[255 - 32*k -: 32];
                end
            end
        end else if (r_state == S_EXPAND) begin
            r_w[r_i] <= w_new;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_nk        <= 4'd4;
            r_nr        <= 4'd10;
            r_nw        <= 6'd44;
            r_i         <= 6'd0;
            r_mod       <= 3'd0;
            r_rcon      <= 8'h01;
            r_done      <= 1'b0;
            r_key_ready <= 1'b0;
            r_err       <= 1'b0;
        end else begin
            r_done <= 1'b0;
            r_err  <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        if (w_len_ok) begin
                            r_nk        <= w_nk;
                            r_nr        <= w_nk + 4'd6;
                            r_nw        <= {w_nk + 4'd7, 2'b00};
                            r_i         <= {2'b00, w_nk};
                            r_mod       <= 3'd0;
                            r_rcon      <= 8'h01;
                            r_key_ready <= 1'b0;
                            r_state     <= S_EXPAND;
                        end else begin
                            r_err <= 1'b1;
                        end
                    end
                end
                S_EXPAND: begin
                    r_i   <= r_i + 6'd1;
                    r_mod <= ({1'b0, r_mod} == r_nk - 4'd1) ? 3'd0 : r_mod + 3'd1;
                    if (w_mod0) begin
                        r_rcon <= w_rcon_next;
                    end
                    if (r_i == r_nw - 6'd1) begin
                        r_state <= S_DONE;
                    end
                end
                S_DONE: begin
                    r_done      <= 1'b1;
                    r_key_ready <= 1'b1;
                    r_state     <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    // Read path: uses key_ready as registered, so a read on the completion
    // edge still returns zero.
    logic         w_rd_ok;
    logic [5:0]   w_rd_base;
    logic [127:0] w_rd_word;

    assign w_rd_ok   = r_key_ready && (rk_rd_idx <= r_nr);
    assign w_rd_base = {rk_rd_idx, 2'b00};
    assign w_rd_word = w_rd_ok ? {r_w[w_rd_base], r_w[w_rd_base | 6'd1],
                                  r_w[w_rd_base | 6'd2], r_w[w_rd_base | 6'd3]}
                               : 128'd0;

    generate
        if (RD_REG) begin : g_rd_reg
            logic [127:0] r_rd_data;
            logic         r_rd_valid;
            always_ff @(posedge clk) begin
                if (rst) begin
                    r_rd_data  <= 128'd0;
                    r_rd_valid <= 1'b0;
                end else begin
                    r_rd_valid <= rk_rd_en;
                    if (rk_rd_en) begin
                        r_rd_data <= w_rd_word;
                    end
                end
            end
            assign rk_rd_data  = r_rd_data;
            assign rk_rd_valid = r_rd_valid;
        end else begin : g_rd_comb
            assign rk_rd_data  = rk_rd_en ? w_rd_word : 128'd0;
            assign rk_rd_valid = rk_rd_en;
        end
    endgenerate

    assign busy      = (r_state == S_EXPAND);
    assign done      = r_done;
    assign key_ready = r_key_ready;
    assign err       = r_err;
    assign dbg_state = r_state;

endmodule

// File: tb/tb_key_schedule_iter.sv
module tb_key_schedule_iter;

    logic         clk;
    logic         rst;
    logic         start;
    logic [1:0]   key_len;
    logic [255:0] key;
    logic         busy;
    logic         done;
    logic         key_ready;
    logic         err;
    logic         rk_rd_en;
    logic [3:0]   rk_rd_idx;
    logic [127:0] rk_rd_data;
    logic         rk_rd_valid;
    logic [1:0]   dbg_state;

    key_schedule_iter #(.MAX_NK(8), .RD_REG(1'b1)) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .key_len    (key_len),
        .key        (key),
        .busy       (busy),
        .done       (done),
        .key_ready  (key_ready),
        .err        (err),
        .rk_rd_en   (rk_rd_en),
        .rk_rd_idx  (rk_rd_idx),
        .rk_rd_data (rk_rd_data),
        .rk_rd_valid(rk_rd_valid),
        .dbg_state  (dbg_state)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    localparam logic [255:0] K128 = {128'h2b7e151628aed2a6abf7158809cf4f3c, 128'h0};
    localparam logic [255:0] K192 = {192'h8e73b0f7da0e6452c810f32b809079e562f8ead2522c6b7b, 64'h0};
    localparam logic [255:0] K256 = 256'h603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4;

    int n_vec = 0;
    int n_err = 0;
    int start_cyc = 0;

    logic [127:0] exp_q[$];
    int           lat_q[$];

    task automatic check1(input string name, input logic act, input logic req);
        n_vec++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s: got %0b expected %0b (cycle %0d)", name, act, req, cyc);
        end
    endtask

    // ---------------- driver tasks ----------------
    task automatic do_start(input logic [1:0] len, input logic [255:0] k,
                            input bit expect_done, input int lat);
        @(negedge clk);
        start   = 1'b1;
        key_len = len;
        key     = k;
        if (expect_done) begin
            start_cyc = cyc + 1;
            lat_q.push_back(lat);
        end
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic rd_chk(input logic [3:0] idx, input logic [127:0] exp);
        @(negedge clk);
        rk_rd_en  = 1'b1;
        rk_rd_idx = idx;
        exp_q.push_back(exp);
        @(negedge clk);
        rk_rd_en = 1'b0;
        check1("rd_valid_latency", rk_rd_valid, 1'b1);
    endtask

    task automatic wait_ready(input string name);
        int n;
        n = 0;
        while (key_ready !== 1'b1 && n < 200) begin
            @(negedge clk);
            n++;
        end
        n_vec++;
        if (key_ready !== 1'b1) begin
            n_err++;
            $display("FAIL %s: key_ready not seen within 200 cycles", name);
        end
    endtask

    // ---------------- scoreboard monitor ----------------
    always @(negedge clk) begin
        if (!rst && rk_rd_valid) begin
            n_vec++;
            if (exp_q.size() == 0) begin
                n_err++;
                $display("FAIL rd_unexpected: data %h with no read pending", rk_rd_data);
            end else begin
                logic [127:0] e;
                e = exp_q.pop_front();
                if (rk_rd_data !== e) begin
                    n_err++;
                    $display("FAIL rd_data: got %h expected %h (cycle %0d)", rk_rd_data, e, cyc);
                end
            end
        end
        if (!rst && done) begin
            n_vec++;
            if (lat_q.size() == 0) begin
                n_err++;
                $display("FAIL done_unexpected: done pulse at cycle %0d", cyc);
            end else begin
                int l;
                l = lat_q.pop_front();
                if (cyc - start_cyc != l) begin
                    n_err++;
                    $display("FAIL done_latency: got %0d expected %0d", cyc - start_cyc, l);
                end
            end
        end
    end

    // ---------------- stimulus ----------------
    initial begin
        rst       = 1'b1;
        start     = 1'b0;
        key_len   = 2'd0;
        key       = '0;
        rk_rd_en  = 1'b0;
        rk_rd_idx = 4'd0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check1("rst_busy", busy, 1'b0);
        check1("rst_done", done, 1'b0);
        check1("rst_key_ready", key_ready, 1'b0);
        check1("rst_err", err, 1'b0);
        check1("rst_rd_valid", rk_rd_valid, 1'b0);
        check1("rst_rd_data_zero", rk_rd_data == 128'd0, 1'b1);
        check1("rst_state_idle", dbg_state == 2'd0, 1'b1);
        rst = 1'b0;

        // nothing expanded yet
        rd_chk(4'd0, 128'd0);

        // illegal key length: one-cycle err, stays idle
        @(negedge clk);
        start   = 1'b1;
        key_len = 2'd3;
        @(negedge clk);
        start = 1'b0;
        check1("err_pulse", err, 1'b1);
        check1("err_busy", busy, 1'b0);
        @(negedge clk);
        check1("err_one_cycle", err, 1'b0);
        check1("err_still_idle", dbg_state == 2'd0, 1'b1);

        // AES-128 with a reading during EXPAND and a stray start while busy
        do_start(2'd0, K128, 1'b1, 41);
        check1("busy_128", busy, 1'b1);
        rd_chk(4'd0, 128'd0);
        @(negedge clk);
        start   = 1'b1;
        key_len = 2'd2;
        key     = K256;
        @(negedge clk);
        start = 1'b0;
        check1("busy_start_no_err", err, 1'b0);
        wait_ready("aes128");
        rd_chk(4'd10, 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);
        rd_chk(4'd0,  128'h2b7e151628aed2a6abf7158809cf4f3c);
        rd_chk(4'd1,  128'ha0fafe1788542cb123a339392a6c7605);
        rd_chk(4'd11, 128'd0);

        // AES-192
        do_start(2'd1, K192, 1'b1, 47);
        check1("key_ready_cleared", key_ready, 1'b0);
        wait_ready("aes192");
        rd_chk(4'd12, 128'he98ba06f448c773c8ecc720401002202);
        rd_chk(4'd0,  128'h8e73b0f7da0e6452c810f32b809079e5);
        rd_chk(4'd13, 128'd0);

        // AES-256
        do_start(2'd2, K256, 1'b1, 53);
        wait_ready("aes256");
        rd_chk(4'd14, 128'hfe4890d1e6188d0b046df344706c631e);
        rd_chk(4'd1,  128'h1f352c073b6108d72d9810a30914dff4);
        rd_chk(4'd2,  128'h9ba354118e6925afa51a8b5f2067fcde);

        // reset in the middle of EXPAND, then immediate restart
        do_start(2'd0, K128, 1'b0, 0);
        repeat (19) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check1("midrst_key_ready", key_ready, 1'b0);
        check1("midrst_busy", busy, 1'b0);
        rst       = 1'b0;
        start     = 1'b1;
        key_len   = 2'd0;
        key       = K128;
        start_cyc = cyc + 1;
        lat_q.push_back(41);
        @(negedge clk);
        start = 1'b0;
        check1("restart_busy", busy, 1'b1);
        rd_chk(4'd10, 128'd0);
        wait_ready("restart128");
        rd_chk(4'd10, 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);

        repeat (4) @(negedge clk);
        check1("queues_drained", (exp_q.size() == 0) && (lat_q.size() == 0), 1'b1);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
